// File: rtl/ahbl_slave_model_if.sv
// AHB-lite bus bundle between a CPU-side master and the slave responder.
// The master holds its address phase while hready is low; it advances only on a posedge that sees hready=1.
interface ahbl_slave_model_if #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 32
);
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [W_DATA-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [W_DATA-1:0] hrdata;

  modport master (
    output haddr, hwrite, htrans, hsize, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, hwrite, htrans, hsize, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahbl_slave_model.sv
// AHB-lite slave responder for CPU harnesses: steerable wait states, two-cycle ERROR,
// optional byte-lane memory and a sticky flag for master-side protocol violations.
module ahbl_slave_model #(
  parameter int W_DATA    = 32,
  parameter int W_ADDR    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int MAX_STALL = 8,
  parameter int ERR_EN    = 1,
  parameter int MEM_MODE  = 1
) (
  input  logic              clock,
  input  logic              reset,
  ahbl_slave_model_if.slave bus,
  input  logic              stall_req,
  input  logic              err_req,
  input  logic [W_DATA-1:0] rand_rdata,
  output logic [7:0]        stall_count,
  output logic              protocol_err,
  output logic [1:0]        state_dbg
);

  localparam int N_BYTES = W_DATA / 8;
  localparam int LANE_W  = $clog2(N_BYTES);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int A_W     = LANE_W + IDX_W;
  localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);
  localparam logic       ERR_ON      = (ERR_EN != 0);
  localparam logic       MEM_ON      = (MEM_MODE != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  state_t            state;
  logic [7:0]        stall_cnt_q;
  logic              perr_q;

  // Captured address phase; only the bits that select a lane or a memory word are kept.
  logic [A_W-1:0]    dp_addr;
  logic              dp_write;
  logic [2:0]        dp_size;
  logic              dp_size_bad;
  logic              dp_misaligned;

  logic [W_ADDR-1:0] prev_haddr;
  logic [1:0]        prev_htrans;
  logic              prev_hwrite;
  logic [2:0]        prev_hsize;
  logic              prev_stall;

  logic [W_DATA-1:0] mem [MEM_DEPTH];

  logic              err_take;
  logic              stall_take;
  logic              complete;
  logic              hready_c;
  logic              hresp_c;
  logic              accept;
  logic              in_size_bad;
  logic              in_misaligned;
  logic              proto_viol;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [N_BYTES-1:0] wmask;
  logic [W_DATA-1:0] rd_word;
  int                byte_off;
  int                byte_len;

  // An oversize transfer can never be honoured, so it errors even when injection is off.
  assign err_take   = (ERR_ON && err_req) || dp_size_bad;
  assign stall_take = stall_req && (stall_cnt_q < MAX_STALL_C);

  always_comb begin
    hready_c = 1'b1;
    hresp_c  = 1'b0;
    complete = 1'b0;
    case (state)
      DATA: begin
        if (err_take) begin
          hready_c = 1'b0;
          hresp_c  = 1'b1;
        end else if (stall_take) begin
          hready_c = 1'b0;
        end else begin
          complete = 1'b1;
        end
      end
      ERR1: begin
        hready_c = 1'b0;
        hresp_c  = 1'b1;
      end
      ERR2: begin
        hresp_c  = 1'b1;
      end
      default: begin
        hready_c = 1'b1;
      end
    endcase
  end

  assign accept = hready_c && bus.htrans[1];

  assign in_size_bad = (bus.hsize > 3'(LANE_W));

  always_comb begin
    in_misaligned = 1'b0;
    for (int i = 0; i < LANE_W; i++) begin
      if ((i < int'(bus.hsize)) && bus.haddr[i]) in_misaligned = 1'b1;
    end
  end

  // Only a wait cycle obliges the master to hold; the first data-phase cycle may show a new address.
  assign proto_viol = (state == DATA) && prev_stall && prev_htrans[1] &&
                      ({bus.htrans, bus.haddr, bus.hwrite, bus.hsize} !=
                       {prev_htrans, prev_haddr, prev_hwrite, prev_hsize});

  always_comb begin
    byte_off = int'(dp_addr[LANE_W-1:0]);
    byte_len = 32'(1) << dp_size;
    wmask    = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      wmask[b] = (b >= byte_off) && (b < byte_off + byte_len);
    end
  end

  assign mem_idx = dp_addr[LANE_W +: IDX_W];
  assign mem_we  = complete && dp_write && !dp_misaligned && !dp_size_bad;
  assign rd_word = MEM_ON ? mem[mem_idx] : rand_rdata;

  assign bus.hready = hready_c;
  assign bus.hresp  = hresp_c;
  assign bus.hrdata = (complete && !dp_write) ? rd_word : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      stall_cnt_q   <= 8'd0;
      perr_q        <= 1'b0;
      dp_addr       <= '0;
      dp_write      <= 1'b0;
      dp_size       <= 3'd0;
      dp_size_bad   <= 1'b0;
      dp_misaligned <= 1'b0;
      prev_haddr    <= '0;
      prev_htrans   <= 2'b00;
      prev_hwrite   <= 1'b0;
      prev_hsize    <= 3'd0;
      prev_stall    <= 1'b0;
    end else begin
      prev_haddr  <= bus.haddr;
      prev_htrans <= bus.htrans;
      prev_hwrite <= bus.hwrite;
      prev_hsize  <= bus.hsize;
      prev_stall  <= (state == DATA) && !hready_c;

      if (proto_viol) perr_q <= 1'b1;

      if (accept) begin
        state         <= DATA;
        stall_cnt_q   <= 8'd0;
        dp_addr       <= bus.haddr[A_W-1:0];
        dp_write      <= bus.hwrite;
        dp_size       <= bus.hsize;
        dp_size_bad   <= in_size_bad;
        dp_misaligned <= in_misaligned && !in_size_bad;
        if (in_size_bad || in_misaligned) perr_q <= 1'b1;
      end else begin
        case (state)
          DATA: begin
            // The DATA cycle that takes the error is itself the hready=0/hresp=1 cycle.
            if (err_take) begin
              state <= ERR2;
            end else if (stall_take) begin
              stall_cnt_q <= stall_cnt_q + 8'd1;
            end else begin
              state <= IDLE;
            end
          end
          ERR1:    state <= ERR2;
          ERR2:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < N_BYTES; b++) begin
        if (wmask[b]) mem[mem_idx][b*8 +: 8] <= bus.hwdata[b*8 +: 8];
      end
    end
  end

  assign stall_count  = stall_cnt_q;
  assign protocol_err = perr_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_ahbl_slave_model.sv
// Directed bench for ahbl_slave_model: the driver queues each transfer's expected response,
// a negedge monitor pops and compares when the data phase completes.
module tb_ahbl_slave_model;
  localparam int W_DATA    = 32;
  localparam int W_ADDR    = 32;
  localparam int MEM_DEPTH = 256;
  localparam int MAX_STALL = 8;
  localparam int REC_W     = 42;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              stall_req;
  logic              err_req;
  logic [W_DATA-1:0] rand_rdata;
  logic [7:0]        stall_count;
  logic              protocol_err;
  logic [1:0]        state_dbg;

  ahbl_slave_model_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) bus ();

  ahbl_slave_model #(
    .W_DATA(W_DATA), .W_ADDR(W_ADDR), .MEM_DEPTH(MEM_DEPTH),
    .MAX_STALL(MAX_STALL), .ERR_EN(1), .MEM_MODE(1)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .stall_req   (stall_req),
    .err_req     (err_req),
    .rand_rdata  (rand_rdata),
    .stall_count (stall_count),
    .protocol_err(protocol_err),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  // record: {check_rdata, exp_hresp, exp_waits[7:0], exp_rdata[31:0]}
  logic [REC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver: one non-pipelined transfer, bus returns to IDLE during its data phase
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic stall, input logic err,
                      input logic [7:0] exp_waits, input logic exp_resp,
                      input logic [31:0] exp_rdata);
    int n;
    exp_q.push_back({~wr, exp_resp, exp_waits, exp_rdata});
    bus.haddr  = addr;
    bus.hwrite = wr;
    bus.hsize  = size;
    bus.htrans = 2'b10;
    stall_req  = stall;
    err_req    = err;
    tick();
    bus.htrans = 2'b00;
    bus.hwdata = wdata;
    #1;
    n = 0;
    while (!bus.hready && n < 40) begin
      tick();
      n++;
    end
    check("xfer_done", 32'(bus.hready), 32'd1);
    tick();
    stall_req  = 1'b0;
    err_req    = 1'b0;
    bus.hwdata = '0;
  endtask

  // scoreboard monitor
  logic        in_dp = 1'b0;
  logic [31:0] waits = 0;
  logic [31:0] ones  = 0;

  always @(negedge clock) begin
    logic [REC_W-1:0] rec;
    if (reset) begin
      in_dp = 1'b0;
      waits = 0;
      ones  = 0;
    end else begin
      if (in_dp) begin
        if (!bus.hready) begin
          waits = waits + 1;
          if (bus.hresp) ones = ones + 1;
        end else if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'(exp_q.size()), 32'd1);
          waits = 0;
          ones  = 0;
        end else begin
          rec = exp_q.pop_front();
          check("wait_cycles", waits, 32'(rec[39:32]));
          check("wait_hresp_ones", ones, rec[40] ? 32'(rec[39:32]) : 32'd0);
          check("final_hresp", 32'(bus.hresp), 32'(rec[40]));
          check("hrdata", bus.hrdata, rec[41] ? rec[31:0] : 32'd0);
          waits = 0;
          ones  = 0;
        end
      end
      if (!in_dp || bus.hready) in_dp = bus.hready && bus.htrans[1];
    end
  end

  initial begin
    bus.haddr  = '0;
    bus.hwrite = 1'b0;
    bus.htrans = 2'b00;
    bus.hsize  = 3'd0;
    bus.hwdata = '0;
    stall_req  = 1'b0;
    err_req    = 1'b0;
    rand_rdata = 32'h0BAD0BAD;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_hready", 32'(bus.hready), 32'd1);
    check("rst_hresp", 32'(bus.hresp), 32'd0);
    check("rst_hrdata", bus.hrdata, 32'd0);
    check("rst_stall_count", 32'(stall_count), 32'd0);
    check("rst_protocol_err", 32'(protocol_err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // zero-wait write then read
    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0,        1'b0, 1'b0, 8'd0, 1'b0, 32'hDEADBEEF);

    // stall held: exactly MAX_STALL waits
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 1'b0, 8'd8, 1'b0, 32'hDEADBEEF);
    check("stall_count_held", 32'(stall_count), 32'd8);

    // error on a write: two-cycle ERROR, memory untouched
    xfer(1'b1, 32'h10, 3'd2, 32'h12345678, 1'b0, 1'b1, 8'd1, 1'b1, 32'h0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0,        1'b0, 1'b0, 8'd0, 1'b0, 32'hDEADBEEF);
    check("no_protocol_err_yet", 32'(protocol_err), 32'd0);

    // byte lanes and index aliasing
    xfer(1'b1, 32'h10,  3'd2, 32'h11223344, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0);
    xfer(1'b1, 32'h13,  3'd0, 32'hAAAAAAAA, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0);
    xfer(1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 1'b0, 8'd0, 1'b0, 32'hAA223344);
    xfer(1'b1, 32'h12,  3'd1, 32'h55665566, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0);
    xfer(1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 1'b0, 8'd0, 1'b0, 32'h55663344);
    xfer(1'b1, 32'h410, 3'd2, 32'hCAFEF00D, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0);
    xfer(1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 1'b0, 8'd0, 1'b0, 32'hCAFEF00D);

    // IDLE/BUSY ignore stall and error requests
    stall_req = 1'b1;
    err_req   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.htrans = (i == 1) ? 2'b01 : 2'b00;
      tick();
      check("idle_hready", 32'(bus.hready), 32'd1);
      check("idle_hresp", 32'(bus.hresp), 32'd0);
      check("idle_state", 32'(state_dbg), 32'd0);
    end
    stall_req  = 1'b0;
    err_req    = 1'b0;
    bus.htrans = 2'b00;

    // misaligned word write: OKAY, suppressed, flagged
    xfer(1'b1, 32'h11, 3'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0);
    check("misalign_protocol_err", 32'(protocol_err), 32'd1);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0, 32'hCAFEF00D);

    // oversize transfer is forced to ERROR
    xfer(1'b1, 32'h10, 3'd3, 32'h0, 1'b0, 1'b0, 8'd1, 1'b1, 32'h0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0, 32'hCAFEF00D);

    // reset clears the flag but keeps memory
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("reset_clears_perr", 32'(protocol_err), 32'd0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0, 32'hCAFEF00D);

    // address changed while stalled, then reset mid-stall drops the write
    bus.haddr  = 32'h10;
    bus.hwrite = 1'b1;
    bus.hsize  = 3'd2;
    bus.htrans = 2'b10;
    stall_req  = 1'b1;
    tick();
    bus.hwdata = 32'h55555555;
    bus.haddr  = 32'h20;
    bus.hwrite = 1'b0;
    bus.htrans = 2'b10;
    tick();
    bus.haddr  = 32'h24;
    tick();
    check("perr_set", 32'(protocol_err), 32'd1);
    tick();
    check("perr_sticky", 32'(protocol_err), 32'd1);
    check("still_stalled", 32'(bus.hready), 32'd0);
    reset      = 1'b1;
    bus.htrans = 2'b00;
    stall_req  = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_hready", 32'(bus.hready), 32'd1);
    check("midrst_perr", 32'(protocol_err), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    check("midrst_stall_count", 32'(stall_count), 32'd0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0, 32'hCAFEF00D);

    tick();
    tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
